// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and state encoding for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int WORD_SIZE_DEF    = 16;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

  // Saturating increment of the D-grant streak, capped at the starvation limit.
  function automatic logic [3:0] streak_inc(input logic [3:0] cur, input logic [3:0] lim);
    logic [3:0] nxt;
    if (cur >= lim) begin
      nxt = lim;
    end else begin
      nxt = cur + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between fetch (I) and memory-stage (D) requesters,
// one transaction at a time, with D priority bounded by a starvation limit.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE    = WORD_SIZE_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_ready,
  output logic                 i_stall,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 d_stall,
  output logic                 m_req,
  output logic                 m_we,
  output logic [WORD_SIZE-1:0] m_addr,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  input  logic                 m_ready
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_e           state_q, state_d;
  logic [3:0]           streak_q, streak_d;
  logic                 m_req_q, m_req_d;
  logic                 m_we_q, m_we_d;
  logic [WORD_SIZE-1:0] m_addr_q, m_addr_d;
  logic [WORD_SIZE-1:0] m_wdata_q, m_wdata_d;
  logic                 d_wins_s;

  // D has priority unless I has already been passed over LIMIT times in a row.
  assign d_wins_s = d_req & ~(i_req & (streak_q == LIMIT));

  // Next-state, grant capture and streak update.
  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (d_wins_s) begin
          state_d   = ST_BUSY_D;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          if (i_req) begin
            streak_d = streak_inc(streak_q, LIMIT);
          end else begin
            streak_d = 4'd0;
          end
        end else if (i_req) begin
          state_d   = ST_BUSY_I;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = {WORD_SIZE{1'b0}};
          streak_d  = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (m_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    m_req_d = (state_d != ST_IDLE);
  end

  // State and memory-side registers; synchronous reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      streak_q  <= 4'd0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= {WORD_SIZE{1'b0}};
      m_wdata_q <= {WORD_SIZE{1'b0}};
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

  // A flushed fetch (i_req dropped) still completes on the memory side but is not acknowledged.
  assign i_ready = (state_q == ST_BUSY_I) & m_ready & i_req;
  assign d_ready = (state_q == ST_BUSY_D) & m_ready;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign i_stall = i_req & ~i_ready;
  assign d_stall = d_req & ~d_ready;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters: the fetch stage (I-side, read-only) and the memory stage (D-side, load/store driven by the decoded MemRead/MemWrite).
- One transaction is outstanding at a time. Pipeline stall requests are asserted while either side waits.
- Sits between the pipeline datapath and the memory model. It replaces direct memory wiring in the CPU top.

Parameters:
- WORD_SIZE, 16, address/data width; comes from the shared opcodes header.
- STARVE_LIMIT, 4, maximum consecutive D grants while I is pending before I is forced; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held until i_ready
- i_addr  in  WORD_SIZE  fetch address
- i_rdata  out  WORD_SIZE  fetched word, valid when i_ready
- i_ready  out  1  fetch complete, one-cycle pulse
- i_stall  out  1  fetch-stage stall
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  WORD_SIZE  data address
- d_wdata  in  WORD_SIZE  store data
- d_rdata  out  WORD_SIZE  load data, valid when d_ready
- d_ready  out  1  data complete, one-cycle pulse
- d_stall  out  1  memory-stage stall
- m_req  out  1  memory request, held high while busy
- m_we  out  1  memory write enable
- m_addr  out  WORD_SIZE  memory address
- m_wdata  out  WORD_SIZE  memory write data
- m_rdata  in  WORD_SIZE  memory read data, valid with m_ready
- m_ready  in  1  memory completion, one-cycle pulse, at least 1 cycle after m_req rises

Behaviour:
- State machine: IDLE, BUSY_I, BUSY_D.
- Reset (synchronous, wins over everything):
  - state = IDLE, streak counter = 0.
  - m_req = m_we = 0; m_addr = m_wdata = 0.
  - i_ready = d_ready = 0.
  - i_stall = i_req and d_stall = d_req, as in IDLE.
- Arbitration in IDLE, decided at the clock edge:
  - d_req only -> BUSY_D.
  - i_req only -> BUSY_I.
  - Both requesting: D wins unless streak == STARVE_LIMIT, in which case I wins.
  - Neither -> stay in IDLE.
- Grant edge: m_we, m_addr and m_wdata are registered from the winning requester. m_we is forced to 0 for I.
- BUSY_x:
  - m_req = 1. Memory-side outputs are stable for the whole transaction and ignore requester input changes.
- Completion:
  - In BUSY_x with m_ready = 1: x_ready = 1 combinationally, x_rdata = m_rdata passthrough.
  - Next state is IDLE.
  - Both ready outputs are 0 in every other state/cycle. A stray m_ready in IDLE is ignored.
- Turnaround:
  - Minimum request-to-request spacing is 1 IDLE cycle.
  - Requester input in the cycle after its ready pulse is a new request.
- Latency: grant edge -> m_req high next cycle. Total = 1 (arbitration) + memory latency.
- Streak counter (4-bit):
  - D grant with i_req high -> increments, saturating at STARVE_LIMIT.
  - D grant with i_req low -> clears to 0.
  - I grant -> clears to 0.
- Stalls:
  - i_stall = i_req & ~i_ready.
  - d_stall = d_req & ~d_ready.
  - Both are combinational, so the pipeline advances in the ready cycle.
- I-side withdrawal (branch flush):
  - If i_req is 0 in the m_ready cycle of BUSY_I, the transaction still finishes.
  - i_ready stays 0 and the data is discarded.
  - A new i_req is arbitrated from IDLE.
- D-side withdrawal is illegal; the bench asserts d_req stays stable in BUSY_D. d_rdata is don't-care for stores, but d_ready still pulses.
- Reset mid-transaction: returns to IDLE immediately with m_req = 0. The memory model must drop any pending access when m_req falls.

Decomposition:
- Shared header next to opcodes.v: state encodings (IDLE = 0, BUSY_I = 1, BUSY_D = 2) and the STARVE_LIMIT default. WORD_SIZE is reused from opcodes.v.
- No sub-module needed; the streak counter is inline. A behavioural memory model with a programmable latency is a bench-only module.

Test Plan:
- I-only fetch, memory latency 2, addr 0x0010 holding 0x6A05:
  - m_req rises 1 cycle after i_req.
  - i_ready pulses 3 cycles after i_req with i_rdata = 0x6A05.
  - i_stall is 1 for cycles 0..2.
- Simultaneous i_req and d_req (store 0xBEEF to 0x0080):
  - D granted first: m_we = 1, m_addr = 0x0080, m_wdata = 0xBEEF.
  - After d_ready and 1 IDLE cycle, I is granted.
  - Memory[0x0080] = 0xBEEF.
- Starvation, STARVE_LIMIT = 4: i_req held and d_req re-raised every turnaround.
  - Exactly 4 D grants, then an I grant.
  - Streak returns to 0; next contention D wins again.
- I flush: i_req dropped in the middle of BUSY_I.
  - m_req stays high until m_ready; i_ready never pulses.
  - A new i_req to 0x0020 is granted on the IDLE cycle after.
- Reset asserted in the 2nd cycle of BUSY_D:
  - Next cycle state = IDLE, m_req = 0, d_ready = 0.
  - A late m_ready from the model produces no ready pulse.
- Back-to-back loads 0x0001, 0x0002 (latency 1):
  - d_ready pulses are exactly 3 cycles apart.
  - d_rdata matches memory on each pulse.
